ft_recovery: RTL and testbench

//  Read-back/restore side of the lockstep fault-tolerance path: the checkpoint datapath

---
 rtl/ft_pkg.sv | 25 ++
 rtl/ft_recovery_if.sv | 37 +++
 rtl/ft_recovery.sv | 112 +++++++++++
 tb/tb_ft_recovery.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared types and constants for the lockstep fault-recovery path.
// Also used by the shadow GPR file, which is why the register count lives here.
package ft_pkg;

    localparam int unsigned FT_ADDR_WIDTH  = 5;
    localparam int unsigned FT_DATA_WIDTH  = 32;
    localparam int unsigned FT_HALT_CYCLES = 2;
    localparam int unsigned FT_CNT_WIDTH   = 8;

    // Number of architectural registers addressed by an addr_width-bit index
    function automatic int unsigned ft_num_regs(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    localparam int unsigned FT_NUM_REGS = ft_num_regs(FT_ADDR_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HALT    = 3'd1,
        RESTORE = 3'd2,
        PC      = 3'd3,
        RESUME  = 3'd4
    } ft_rec_state_e;

endpackage

// File: rtl/ft_recovery_if.sv
// Bundle between the recovery block, the shadow GPR file / saved-PC register and the cores.
// master = recovery block, slave = the surrounding environment.
interface ft_recovery_if
    import ft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = FT_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = FT_CNT_WIDTH
);

    logic                  error_i;
    logic [DATA_WIDTH-1:0] spc_i;
    logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
    logic [DATA_WIDTH-1:0] sgpr_rdata_i;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  pc_we_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  halt_o;
    logic                  resume_o;
    logic                  busy_o;
    logic [CNT_WIDTH-1:0]  rec_count_o;

    modport master (
        input  error_i, spc_i, sgpr_rdata_i,
        output sgpr_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output pc_we_o, pc_o, halt_o, resume_o, busy_o, rec_count_o
    );

    modport slave (
        output error_i, spc_i, sgpr_rdata_i,
        input  sgpr_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  pc_we_o, pc_o, halt_o, resume_o, busy_o, rec_count_o
    );

endinterface

// File: rtl/ft_recovery.sv
// Lockstep recovery sequencer: on a comparator mismatch, halt and drain both cores,
// copy shadow GPRs 1..N-1 into the core register files, reload the PC, then resume.
module ft_recovery
    import ft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = FT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = FT_DATA_WIDTH,
    parameter int unsigned HALT_CYCLES = FT_HALT_CYCLES,
    parameter int unsigned CNT_WIDTH   = FT_CNT_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ft_recovery_if.master bus
);

    localparam int unsigned NUM_REGS    = ft_num_regs(ADDR_WIDTH);
    localparam int unsigned DRAIN_WIDTH = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0]  FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [DRAIN_WIDTH-1:0] LAST_DRAIN = DRAIN_WIDTH'(HALT_CYCLES - 1);

    ft_rec_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DRAIN_WIDTH-1:0] drain_q, drain_d;

    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  pc_we_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  halt_q;
    logic                  resume_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  count_q;

    // Next-state, address counter and drain counter; both counters idle at zero
    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        drain_d = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.error_i) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = RESTORE;
                    addr_d  = FIRST_ADDR;
                end else begin
                    drain_d = drain_q + DRAIN_WIDTH'(1);
                end
            end
            RESTORE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = PC;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            PC:      state_d = RESUME;
            RESUME:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; the RF write lags the shadow read by one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            drain_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pc_we_q    <= 1'b0;
            pc_q       <= '0;
            halt_q     <= 1'b0;
            resume_q   <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            rf_we_q    <= (state_q == RESTORE);
            rf_waddr_q <= (state_q == RESTORE) ? addr_q : '0;
            rf_wdata_q <= (state_q == RESTORE) ? bus.sgpr_rdata_i : '0;
            pc_we_q    <= (state_d == PC);
            pc_q       <= (state_d == PC) ? bus.spc_i : '0;
            halt_q     <= (state_d inside {HALT, RESTORE, PC});
            resume_q   <= (state_d == RESUME);
            busy_q     <= (state_d != IDLE);
            if ((state_d == RESUME) && (count_q != '1)) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.sgpr_raddr_o = addr_q;
    assign bus.rf_we_o      = rf_we_q;
    assign bus.rf_waddr_o   = rf_waddr_q;
    assign bus.rf_wdata_o   = rf_wdata_q;
    assign bus.pc_we_o      = pc_we_q;
    assign bus.pc_o         = pc_q;
    assign bus.halt_o       = halt_q;
    assign bus.resume_o     = resume_q;
    assign bus.busy_o       = busy_q;
    assign bus.rec_count_o  = count_q;

endmodule

// File: tb/tb_ft_recovery.sv
// Bench for ft_recovery: cycle-indexed timeline model of one recovery, plus a second
// instance with a 2-bit event counter to observe saturation.
module tb_ft_recovery;
    import ft_pkg::*;

    localparam int unsigned H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        err;
    logic [31:0] spc;
    logic [31:0] shadow [FT_NUM_REGS];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count  = 0;
    int exp_count2 = 0;

    ft_recovery_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();
    ft_recovery_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(2)) bus2 ();

    assign bus.error_i       = err;
    assign bus.spc_i         = spc;
    assign bus.sgpr_rdata_i  = shadow[bus.sgpr_raddr_o];
    assign bus2.error_i      = err;
    assign bus2.spc_i        = spc;
    assign bus2.sgpr_rdata_i = shadow[bus2.sgpr_raddr_o];

    ft_recovery #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .HALT_CYCLES(H), .CNT_WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    ft_recovery #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .HALT_CYCLES(H), .CNT_WIDTH(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [86:0] obs();
        return {bus.halt_o, bus.busy_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o,
                bus.pc_we_o, bus.pc_o, bus.resume_o, bus.sgpr_raddr_o, bus.rec_count_o};
    endfunction

    task automatic fill_shadow(input bit random_fill);
        for (int k = 0; k < int'(FT_NUM_REGS); k++) begin
            shadow[k] = random_fill ? $urandom : (32'hA5A5_0000 + 32'(k));
        end
    endtask

    // One recovery, error already high in the current cycle t; walks cycles t+1..t+H+34.
    // Error stays high for cycles c < hold_until; with noise it toggles randomly while busy.
    task automatic check_recovery(input int unsigned hold_until, input bit noise,
                                  input bit change_spc, input logic [31:0] new_spc);
        int unsigned writes[$];
        int unsigned resumes = 0;
        bit order_ok;
        logic [46:0] act, exp;
        for (int unsigned c = 1; c <= H + 34; c++) begin
            logic e_we;
            logic [4:0]  e_addr, e_raddr;
            logic [31:0] e_data;
            tick();
            if (change_spc && c == 1) spc = new_spc;
            if (c < hold_until) err = 1'b1;
            else if (noise && c <= H + 33) err = 1'($urandom_range(0, 1));
            else err = 1'b0;
            e_we    = (c >= H + 2) && (c <= H + 32);
            e_addr  = e_we ? 5'(c - H - 1) : 5'd0;
            e_data  = e_we ? shadow[c - H - 1] : 32'd0;
            e_raddr = (c >= H + 1 && c <= H + 31) ? 5'(c - H) : 5'd0;
            exp = {c <= H + 32, c <= H + 33, e_we, e_addr, e_data,
                   c == H + 32, c == H + 33, e_raddr};
            act = {bus.halt_o, bus.busy_o, bus.rf_we_o,
                   e_we ? bus.rf_waddr_o : 5'd0, e_we ? bus.rf_wdata_o : 32'd0,
                   bus.pc_we_o, bus.resume_o, bus.sgpr_raddr_o};
            n_checks++;
            if (act !== exp) $display("FAIL timeline c=%0d got %h want %h", c, act, exp);
            else n_pass++;
            if (bus.rf_we_o === 1'b1) writes.push_back(int'(bus.rf_waddr_o));
            if (bus.resume_o === 1'b1) resumes++;
            if (c == H + 32) begin
                n_checks++;
                if (bus.pc_o !== spc) $display("FAIL pc_value got %h want %h", bus.pc_o, spc);
                else n_pass++;
            end
        end
        order_ok = (writes.size() == 31);
        foreach (writes[i]) if (writes[i] != i + 1) order_ok = 1'b0;
        n_checks++;
        if (!order_ok) $display("FAIL write_order got %0d writes want 31 ascending 1..31", writes.size());
        else n_pass++;
        n_checks++;
        if (resumes != 1) $display("FAIL resume_count got %0d want 1", resumes);
        else n_pass++;
        if (exp_count < 255) exp_count++;
        if (exp_count2 < 3) exp_count2++;
        n_checks++;
        if (bus.rec_count_o !== 8'(exp_count))
            $display("FAIL rec_count got %0d want %0d", bus.rec_count_o, exp_count);
        else n_pass++;
        n_checks++;
        if (bus2.rec_count_o !== 2'(exp_count2))
            $display("FAIL rec_count_sat got %0d want %0d", bus2.rec_count_o, exp_count2);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        err = 1'b0;
        spc = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 0;
        exp_count2 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (obs() !== 87'd0) $display("FAIL reset_idle cycle %0d got %h want 0", i, obs());
            else n_pass++;
        end
        n_checks++;
        if (bus2.rec_count_o !== 2'd0) $display("FAIL reset_count2 got %0d want 0", bus2.rec_count_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        fill_shadow(1'b0);
        spc = 32'h0000_0400;
        tick();
        err = 1'b1;
        check_recovery(1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_held_error();
        fill_shadow(1'b1);
        spc = $urandom;
        tick();
        err = 1'b1;
        check_recovery(H + 35, 1'b0, 1'b0, 32'd0);
        check_recovery(4, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_shadow(1'b1);
            spc = $urandom;
            repeat ($urandom_range(1, 5)) tick();
            err = 1'b1;
            check_recovery(1, 1'b1, 1'b0, 32'd0);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        fill_shadow(1'b1);
        tick();
        err = 1'b1;
        for (int unsigned c = 1; c <= H + 10; c++) begin
            tick();
            err = 1'b0;
        end
        n_checks++;
        if (bus.sgpr_raddr_o !== 5'd10) $display("FAIL mid_addr got %0d want 10", bus.sgpr_raddr_o);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 0;
        exp_count2 = 0;
        n_checks++;
        if (obs() !== 87'd0) $display("FAIL mid_reset got %h want 0", obs());
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.resume_o || bus.rf_we_o || bus.pc_we_o || bus.halt_o || bus.busy_o) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL mid_quiet got %0d active cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 5; r++) begin
            fill_shadow(1'b1);
            spc = $urandom;
            tick();
            err = 1'b1;
            check_recovery(1, 1'b0, 1'b0, 32'd0);
        end
        n_checks++;
        if (bus2.rec_count_o !== 2'd3) $display("FAIL sat_final got %0d want 3", bus2.rec_count_o);
        else n_pass++;
    endtask

    task automatic test_spc_late();
        fill_shadow(1'b1);
        spc = 32'h0000_0100;
        tick();
        err = 1'b1;
        check_recovery(1, 1'b0, 1'b1, 32'h0000_0200);
        n_checks++;
        if (spc !== 32'h0000_0200) $display("FAIL spc_drive got %h want 200", spc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_error();
        test_random();
        test_reset_mid();
        test_saturation();
        test_spc_late();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
